// File: rtl/round_controller.sv
// Round sequencer for a two-player door game: start -> timed countdown -> wait for CPU
// evaluation -> inter-round gap -> next round or game over.
module round_controller #(
    parameter int unsigned TICKS_PER_SEC = 25000000,
    parameter int unsigned ROUND_SECS    = 10,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned MAX_ROUNDS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] posJ1_in,
    input  logic [3:0] posJ2_in,
    input  logic       ack,
    input  logic [1:0] p1_lives,
    input  logic [1:0] p2_lives,
    output logic       time_up,
    output logic [3:0] posJ1,
    output logic [3:0] posJ2,
    output logic [7:0] seconds_left,
    output logic [3:0] round_count,
    output logic       game_over
);

    localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        SECS_INIT  = 8'(ROUND_SECS);
    localparam logic [3:0]        ROUND_LAST = 4'(MAX_ROUNDS);
    localparam logic [3:0]        DOOR_INIT  = 4'b1000;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StEval,
        StNext,
        StOver
    } state_e;

    state_e            state_q;
    logic [TICK_W-1:0] tick_q;
    logic [GAP_W-1:0]  gap_q;

    logic tick_wrap;
    logic round_end;
    logic gap_done;
    logic game_end;

    always_comb begin
        tick_wrap = (tick_q == TICK_LAST);
        // Last tick of the final second: the edge that ends the round.
        round_end = tick_wrap && (seconds_left == 8'd1);
        gap_done  = (gap_q == GAP_LAST);
        game_end  = (p1_lives == 2'd0) || (p2_lives == 2'd0) || (round_count >= ROUND_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            gap_q        <= '0;
            time_up      <= 1'b0;
            game_over    <= 1'b0;
            posJ1        <= DOOR_INIT;
            posJ2        <= DOOR_INIT;
            seconds_left <= 8'd0;
            round_count  <= 4'd0;
        end else begin
            case (state_q)
                StIdle, StOver: begin
                    if (start) begin
                        state_q      <= StCount;
                        round_count  <= 4'd1;
                        seconds_left <= SECS_INIT;
                        tick_q       <= '0;
                        posJ1        <= DOOR_INIT;
                        posJ2        <= DOOR_INIT;
                        game_over    <= 1'b0;
                    end
                end

                StCount: begin
                    if (round_end) begin
                        // Selections freeze on this edge; inputs seen here are discarded.
                        state_q      <= StEval;
                        time_up      <= 1'b1;
                        seconds_left <= 8'd0;
                        tick_q       <= '0;
                    end else begin
                        if (tick_wrap) begin
                            tick_q <= '0;
                            if (seconds_left != 8'd0) begin
                                seconds_left <= seconds_left - 8'd1;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                        if ($onehot(posJ1_in)) begin
                            posJ1 <= posJ1_in;
                        end
                        if ($onehot(posJ2_in)) begin
                            posJ2 <= posJ2_in;
                        end
                    end
                end

                StEval: begin
                    if (ack) begin
                        state_q <= StNext;
                        time_up <= 1'b0;
                        gap_q   <= '0;
                    end
                end

                StNext: begin
                    if (gap_done) begin
                        gap_q <= '0;
                        if (game_end) begin
                            state_q   <= StOver;
                            game_over <= 1'b1;
                        end else begin
                            state_q      <= StCount;
                            seconds_left <= SECS_INIT;
                            tick_q       <= '0;
                            if (round_count != 4'hF) begin
                                round_count <= round_count + 4'd1;
                            end
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed scenarios plus random traffic, all checked every cycle
// against a timeline model of the game.
module tb_round_controller;

    localparam int T = 4;
    localparam int R = 3;
    localparam int G = 2;
    localparam int M = 2;

    localparam int MD_IDLE  = 0;
    localparam int MD_COUNT = 1;
    localparam int MD_EVAL  = 2;
    localparam int MD_GAP   = 3;
    localparam int MD_OVER  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] posJ1_in = 4'd0;
    logic [3:0] posJ2_in = 4'd0;
    logic       ack = 1'b0;
    logic [1:0] p1_lives = 2'd2;
    logic [1:0] p2_lives = 2'd2;
    logic       time_up;
    logic [3:0] posJ1;
    logic [3:0] posJ2;
    logic [7:0] seconds_left;
    logic [3:0] round_count;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    // Model: phase plus how far into it we are, in cycles.
    int         m_mode = MD_IDLE;
    int         m_ticks = 0;
    int         m_gap = 0;
    int         m_secs = 0;
    int         m_round = 0;
    logic [3:0] m_p1 = 4'b1000;
    logic [3:0] m_p2 = 4'b1000;

    round_controller #(
        .TICKS_PER_SEC(T),
        .ROUND_SECS   (R),
        .GAP_CYCLES   (G),
        .MAX_ROUNDS   (M)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .posJ1_in    (posJ1_in),
        .posJ2_in    (posJ2_in),
        .ack         (ack),
        .p1_lives    (p1_lives),
        .p2_lives    (p2_lives),
        .time_up     (time_up),
        .posJ1       (posJ1),
        .posJ2       (posJ2),
        .seconds_left(seconds_left),
        .round_count (round_count),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input int dut_val, input int mdl_val, input int lit);
        check({name, "_dut"}, dut_val, lit);
        check({name, "_model"}, mdl_val, lit);
    endtask

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_ticks = 0;
        m_gap   = 0;
        m_secs  = 0;
        m_round = 0;
        m_p1    = 4'b1000;
        m_p2    = 4'b1000;
    endtask

    task automatic model_step();
        case (m_mode)
            MD_IDLE, MD_OVER: begin
                if (start) begin
                    m_mode  = MD_COUNT;
                    m_ticks = 0;
                    m_round = 1;
                    m_secs  = R;
                    m_p1    = 4'b1000;
                    m_p2    = 4'b1000;
                end
            end
            MD_COUNT: begin
                m_ticks++;
                if (m_ticks == R * T) begin
                    m_mode = MD_EVAL;
                    m_secs = 0;
                end else begin
                    m_secs = R - m_ticks / T;
                    if ($countones(posJ1_in) == 1) m_p1 = posJ1_in;
                    if ($countones(posJ2_in) == 1) m_p2 = posJ2_in;
                end
            end
            MD_EVAL: begin
                if (ack) begin
                    m_mode = MD_GAP;
                    m_gap  = 0;
                end
            end
            MD_GAP: begin
                m_gap++;
                if (m_gap == G) begin
                    if (p1_lives == 2'd0 || p2_lives == 2'd0 || m_round == M) begin
                        m_mode = MD_OVER;
                    end else begin
                        m_mode  = MD_COUNT;
                        m_ticks = 0;
                        m_round++;
                        m_secs  = R;
                    end
                end
            end
            default: m_mode = MD_IDLE;
        endcase
    endtask

    // Compare process: advance the model on every edge / reset event, then check the DUT.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
            #1;
            check("time_up", int'(time_up), int'(m_mode == MD_EVAL));
            check("game_over", int'(game_over), int'(m_mode == MD_OVER));
            check("seconds_left", int'(seconds_left), m_secs);
            check("round_count", int'(round_count), m_round);
            check("posJ1", int'(posJ1), int'(m_p1));
            check("posJ2", int'(posJ2), int'(m_p2));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        pin("rst_secs", int'(seconds_left), m_secs, 0);
        pin("rst_round", int'(round_count), m_round, 0);
        pin("rst_posJ1", int'(posJ1), int'(m_p1), 8);
        check("rst_time_up", int'(time_up), 0);

        // Round 1: countdown and selection filtering.
        start = 1'b1;
        step(1);
        start = 1'b0;
        pin("r1_secs3", int'(seconds_left), m_secs, 3);
        pin("r1_round1", int'(round_count), m_round, 1);
        posJ1_in = 4'b0001;
        posJ2_in = 4'b0010;
        step(1);
        posJ1_in = 4'b0011;
        step(1);
        posJ1_in = 4'b0000;
        step(1);
        pin("posJ1_filter", int'(posJ1), int'(m_p1), 1);
        step(1);
        pin("r1_secs2", int'(seconds_left), m_secs, 2);
        step(4);
        pin("r1_secs1", int'(seconds_left), m_secs, 1);
        step(3);
        check("r1_no_time_up_at_11", int'(time_up), 0);
        posJ2_in = 4'b0100;
        step(1);
        posJ2_in = 4'b0000;
        check("r1_time_up_at_12", int'(time_up), 1);
        pin("r1_secs0", int'(seconds_left), m_secs, 0);
        pin("posJ2_frozen", int'(posJ2), int'(m_p2), 2);

        // Hold EVAL for 50 cycles with a stray start, then ack.
        start = 1'b1;
        step(3);
        start = 1'b0;
        step(47);
        check("eval_hold", int'(time_up), 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("ack_clears", int'(time_up), 0);
        step(1);
        pin("gap_round1", int'(round_count), m_round, 1);
        step(1);
        pin("r2_round2", int'(round_count), m_round, 2);
        pin("r2_secs3", int'(seconds_left), m_secs, 3);

        // Round 2 ends the game at MAX_ROUNDS.
        step(12);
        check("r2_time_up", int'(time_up), 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(2);
        pin("over_flag", int'(game_over), int'(m_mode == MD_OVER), 1);
        pin("over_round2", int'(round_count), m_round, 2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        pin("restart_round1", int'(round_count), m_round, 1);
        pin("restart_go", int'(game_over), int'(m_mode == MD_OVER), 0);

        // Player 1 out of lives after round 1.
        step(12);
        p1_lives = 2'd0;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(2);
        p1_lives = 2'd2;
        pin("lives_over", int'(game_over), int'(m_mode == MD_OVER), 1);
        pin("lives_round1", int'(round_count), m_round, 1);

        // Asynchronous reset mid-EVAL, then a stray ack in IDLE.
        start = 1'b1;
        step(1);
        start = 1'b0;
        posJ1_in = 4'b0010;
        step(12);
        posJ1_in = 4'b0000;
        pin("pre_rst_posJ1", int'(posJ1), int'(m_p1), 2);
        #2 reset = 1'b1;
        #2;
        pin("async_time_up", int'(time_up), int'(m_mode == MD_EVAL), 0);
        pin("async_posJ1", int'(posJ1), int'(m_p1), 8);
        @(negedge clk);
        reset = 1'b0;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        pin("stray_ack_round", int'(round_count), m_round, 0);
        pin("stray_ack_secs", int'(seconds_left), m_secs, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 15) == 0);
            ack      = ($urandom_range(0, 3) == 0);
            posJ1_in = 4'($urandom_range(0, 15));
            posJ2_in = 4'($urandom_range(0, 15));
            p1_lives = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            p2_lives = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
